vx_mem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single Vortex-style memory port in front of Vortex_mem_slave.
- Port s0 carries GPU core traffic; port s1 carries the debug/loader/dump agent.
- Requests are merged into one registered downstream request stream. The source ID is added as the tag MSB, and responses are steered back by that bit.
- Per-port read-outstanding counters drive `busy` and flow control.

---
 rtl/vx_mem_arb_pkg.sv | 25 ++
 rtl/vx_outst_counter.sv | 38 +++
 rtl/vx_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_vx_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_mem_arb_pkg.sv
// Shared types and default widths for the two-port Vortex memory arbiter.
// Top-level parameters default to these values so the request struct matches them.
package vx_mem_arb_pkg;

   localparam int DEF_DATA_W    = 512;
   localparam int DEF_ADDR_W    = 26;
   localparam int DEF_TAG_W     = 8;
   localparam int DEF_BYTEEN_W  = DEF_DATA_W / 8;
   localparam int DEF_MAX_OUTST = 16;
   localparam int CNT_W         = $clog2(DEF_MAX_OUTST) + 1;

   typedef enum logic {
      SRC_CORE = 1'b0,
      SRC_DBG  = 1'b1
   } src_t;

   typedef struct packed {
      logic                    rw;
      logic [DEF_BYTEEN_W-1:0] byteen;
      logic [DEF_ADDR_W-1:0]   addr;
      logic [DEF_DATA_W-1:0]   data;
      logic [DEF_TAG_W:0]      tag;
   } mem_req_t;

endpackage

// File: rtl/vx_outst_counter.sv
// Per-port count of reads issued downstream whose response has not yet returned.
// A response with nothing outstanding is flagged and ignored rather than wrapping.
module vx_outst_counter
   import vx_mem_arb_pkg::*;
#(
   parameter int MAX_OUTST = DEF_MAX_OUTST,
   parameter int CW        = CNT_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] cnt,
   output logic          at_max,
   output logic          underflow
);

   logic is_zero;

   assign is_zero   = (cnt == '0);
   assign at_max    = (cnt == CW'(MAX_OUTST));
   assign underflow = dec && is_zero;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else begin
         unique case ({inc, dec})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   if (!is_zero) cnt <= cnt - CW'(1);
            2'b11:   if (is_zero) cnt <= CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/vx_mem_arbiter.sv
// Round-robin merge of core (s0) and debug (s1) traffic onto one registered memory port;
// the source id rides in the tag MSB so responses steer back combinationally.
module vx_mem_arbiter
   import vx_mem_arb_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int TAG_W     = DEF_TAG_W,
   parameter int BYTEEN_W  = DATA_W / 8,
   parameter int MAX_OUTST = DEF_MAX_OUTST
) (
   input  logic                clk,
   input  logic                reset,

   input  logic                s0_req_valid,
   input  logic                s0_req_rw,
   input  logic [BYTEEN_W-1:0] s0_req_byteen,
   input  logic [ADDR_W-1:0]   s0_req_addr,
   input  logic [DATA_W-1:0]   s0_req_data,
   input  logic [TAG_W-1:0]    s0_req_tag,
   output logic                s0_req_ready,
   output logic                s0_rsp_valid,
   output logic [DATA_W-1:0]   s0_rsp_data,
   output logic [TAG_W-1:0]    s0_rsp_tag,
   input  logic                s0_rsp_ready,

   input  logic                s1_req_valid,
   input  logic                s1_req_rw,
   input  logic [BYTEEN_W-1:0] s1_req_byteen,
   input  logic [ADDR_W-1:0]   s1_req_addr,
   input  logic [DATA_W-1:0]   s1_req_data,
   input  logic [TAG_W-1:0]    s1_req_tag,
   output logic                s1_req_ready,
   output logic                s1_rsp_valid,
   output logic [DATA_W-1:0]   s1_rsp_data,
   output logic [TAG_W-1:0]    s1_rsp_tag,
   input  logic                s1_rsp_ready,

   output logic                m_req_valid,
   output logic                m_req_rw,
   output logic [BYTEEN_W-1:0] m_req_byteen,
   output logic [ADDR_W-1:0]   m_req_addr,
   output logic [DATA_W-1:0]   m_req_data,
   output logic [TAG_W:0]      m_req_tag,
   input  logic                m_req_ready,

   input  logic                m_rsp_valid,
   input  logic [DATA_W-1:0]   m_rsp_data,
   input  logic [TAG_W:0]      m_rsp_tag,
   output logic                m_rsp_ready,

   output logic                busy,
   output logic                err_unexp_rsp
);

   localparam int CW = $clog2(MAX_OUTST) + 1;

   mem_req_t      obuf_q;
   mem_req_t      req_sel;
   logic          obuf_valid;
   src_t          rr_last;
   src_t          grant;
   src_t          rsp_src;
   logic          free;
   logic          blocked_0, blocked_1;
   logic          eff_0, eff_1;
   logic          accept_0, accept_1, accept;
   logic          dec_0, dec_1;
   logic [CW-1:0] cnt_0, cnt_1;
   logic          at_max_0, at_max_1;
   logic          uflow_0, uflow_1;

   // A read that would overflow its port's counter is invisible to arbitration.
   assign blocked_0 = !s0_req_rw && at_max_0;
   assign blocked_1 = !s1_req_rw && at_max_1;
   assign eff_0     = s0_req_valid && !blocked_0;
   assign eff_1     = s1_req_valid && !blocked_1;
   assign free      = !obuf_valid || m_req_ready;

   // NOTE: defaults first so every path assigns every output -- no latch.
   always_comb begin
      grant   = SRC_CORE;
      req_sel = '0;
      if (eff_1 && (!eff_0 || rr_last == SRC_CORE)) begin
         grant = SRC_DBG;
      end
      if (grant == SRC_DBG) begin
         req_sel = '{rw: s1_req_rw, byteen: s1_req_byteen, addr: s1_req_addr,
                     data: s1_req_data, tag: {SRC_DBG, s1_req_tag}};
      end else begin
         req_sel = '{rw: s0_req_rw, byteen: s0_req_byteen, addr: s0_req_addr,
                     data: s0_req_data, tag: {SRC_CORE, s0_req_tag}};
      end
   end

   assign s0_req_ready = free && (grant == SRC_CORE) && !blocked_0;
   assign s1_req_ready = free && (grant == SRC_DBG)  && !blocked_1;
   assign accept_0     = s0_req_valid && s0_req_ready;
   assign accept_1     = s1_req_valid && s1_req_ready;
   assign accept       = accept_0 || accept_1;

   // NOTE: payload is cleared on reset as well so m_req_* read 0 while held in reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         obuf_valid <= 1'b0;
         obuf_q     <= '0;
         rr_last    <= SRC_DBG;
      end else if (accept) begin
         obuf_valid <= 1'b1;
         obuf_q     <= req_sel;
         rr_last    <= grant;
      end else if (m_req_ready) begin
         obuf_valid <= 1'b0;
      end
   end

   assign m_req_valid  = obuf_valid;
   assign m_req_rw     = obuf_q.rw;
   assign m_req_byteen = obuf_q.byteen;
   assign m_req_addr   = obuf_q.addr;
   assign m_req_data   = obuf_q.data;
   assign m_req_tag    = obuf_q.tag;

   assign rsp_src      = src_t'(m_rsp_tag[TAG_W]);
   assign s0_rsp_valid = m_rsp_valid && (rsp_src == SRC_CORE);
   assign s1_rsp_valid = m_rsp_valid && (rsp_src == SRC_DBG);
   assign s0_rsp_data  = m_rsp_data;
   assign s1_rsp_data  = m_rsp_data;
   assign s0_rsp_tag   = m_rsp_tag[TAG_W-1:0];
   assign s1_rsp_tag   = m_rsp_tag[TAG_W-1:0];
   assign m_rsp_ready  = (rsp_src == SRC_DBG) ? s1_rsp_ready : s0_rsp_ready;
   assign dec_0        = s0_rsp_valid && s0_rsp_ready;
   assign dec_1        = s1_rsp_valid && s1_rsp_ready;

   vx_outst_counter #(.MAX_OUTST(MAX_OUTST), .CW(CW)) u_cnt_0 (
      .clk       (clk),
      .reset     (reset),
      .inc       (accept_0 && !s0_req_rw),
      .dec       (dec_0),
      .cnt       (cnt_0),
      .at_max    (at_max_0),
      .underflow (uflow_0)
   );

   vx_outst_counter #(.MAX_OUTST(MAX_OUTST), .CW(CW)) u_cnt_1 (
      .clk       (clk),
      .reset     (reset),
      .inc       (accept_1 && !s1_req_rw),
      .dec       (dec_1),
      .cnt       (cnt_1),
      .at_max    (at_max_1),
      .underflow (uflow_1)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_unexp_rsp <= 1'b0;
      end else if (uflow_0 || uflow_1) begin
         err_unexp_rsp <= 1'b1;
      end
   end

   assign busy = obuf_valid || (cnt_0 != '0) || (cnt_1 != '0);

endmodule

// File: tb/tb_vx_mem_arbiter.sv
// Scoreboard bench for vx_mem_arbiter: upstream accepts push expected downstream
// beats, downstream handshakes pop and compare; directed steps check arbitration and counters.
module tb_vx_mem_arbiter;
   import vx_mem_arb_pkg::*;

   localparam int DW = DEF_DATA_W;
   localparam int AW = DEF_ADDR_W;
   localparam int TW = DEF_TAG_W;
   localparam int BW = DEF_BYTEEN_W;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          s0_req_valid = 0, s0_req_rw = 0, s0_req_ready, s0_rsp_valid, s0_rsp_ready = 0;
   logic [BW-1:0] s0_req_byteen = '0;
   logic [AW-1:0] s0_req_addr = '0;
   logic [DW-1:0] s0_req_data = '0, s0_rsp_data;
   logic [TW-1:0] s0_req_tag = '0, s0_rsp_tag;
   logic          s1_req_valid = 0, s1_req_rw = 0, s1_req_ready, s1_rsp_valid, s1_rsp_ready = 0;
   logic [BW-1:0] s1_req_byteen = '0;
   logic [AW-1:0] s1_req_addr = '0;
   logic [DW-1:0] s1_req_data = '0, s1_rsp_data;
   logic [TW-1:0] s1_req_tag = '0, s1_rsp_tag;
   logic          m_req_valid, m_req_rw, m_req_ready = 0;
   logic [BW-1:0] m_req_byteen;
   logic [AW-1:0] m_req_addr;
   logic [DW-1:0] m_req_data;
   logic [TW:0]   m_req_tag;
   logic          m_rsp_valid = 0, m_rsp_ready;
   logic [DW-1:0] m_rsp_data = '0;
   logic [TW:0]   m_rsp_tag = '0;
   logic          busy, err_unexp_rsp;

   typedef struct {
      logic          rw;
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic [TW:0]   tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_bad = 0;

   vx_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .s0_req_valid(s0_req_valid), .s0_req_rw(s0_req_rw), .s0_req_byteen(s0_req_byteen),
      .s0_req_addr(s0_req_addr), .s0_req_data(s0_req_data), .s0_req_tag(s0_req_tag),
      .s0_req_ready(s0_req_ready), .s0_rsp_valid(s0_rsp_valid), .s0_rsp_data(s0_rsp_data),
      .s0_rsp_tag(s0_rsp_tag), .s0_rsp_ready(s0_rsp_ready),
      .s1_req_valid(s1_req_valid), .s1_req_rw(s1_req_rw), .s1_req_byteen(s1_req_byteen),
      .s1_req_addr(s1_req_addr), .s1_req_data(s1_req_data), .s1_req_tag(s1_req_tag),
      .s1_req_ready(s1_req_ready), .s1_rsp_valid(s1_rsp_valid), .s1_rsp_data(s1_rsp_data),
      .s1_rsp_tag(s1_rsp_tag), .s1_rsp_ready(s1_rsp_ready),
      .m_req_valid(m_req_valid), .m_req_rw(m_req_rw), .m_req_byteen(m_req_byteen),
      .m_req_addr(m_req_addr), .m_req_data(m_req_data), .m_req_tag(m_req_tag),
      .m_req_ready(m_req_ready),
      .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data), .m_rsp_tag(m_rsp_tag),
      .m_rsp_ready(m_rsp_ready),
      .busy(busy), .err_unexp_rsp(err_unexp_rsp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic rw, input logic [AW-1:0] a, input logic [TW-1:0] t);
      s0_req_valid  = v;
      s0_req_rw     = rw;
      s0_req_addr   = a;
      s0_req_tag    = t;
      s0_req_byteen = '1;
      s0_req_data   = {16{6'h00, a}};
   endtask

   task automatic drive1(input logic v, input logic rw, input logic [AW-1:0] a, input logic [TW-1:0] t);
      s1_req_valid  = v;
      s1_req_rw     = rw;
      s1_req_addr   = a;
      s1_req_tag    = t;
      s1_req_byteen = '1;
      s1_req_data   = {16{6'h3f, a}};
   endtask

   task automatic rsp(input logic v, input logic [TW:0] t);
      m_rsp_valid = v;
      m_rsp_tag   = t;
      m_rsp_data  = {16{32'hA5A5_A5A5}};
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive0(0, 0, '0, '0);
      drive1(0, 0, '0, '0);
      rsp(0, '0);
      m_req_ready  = 1'b0;
      s0_rsp_ready = 1'b0;
      s1_rsp_ready = 1'b0;
      exp_q.delete();
      cyc();
      reset = 1'b1;
   endtask

   // Pop before push: an accept seen now lands in obuf only at the next edge.
   always @(negedge clk) begin
      if (reset) begin
         if (m_req_valid && m_req_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_underrun", m_req_valid, 1'b0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_rw",   m_req_rw, e.rw);
               check("sb_addr", m_req_addr, e.addr);
               check("sb_data", m_req_data[31:0], e.data);
               check("sb_tag",  m_req_tag, e.tag);
            end
         end
         if (s0_req_valid && s0_req_ready)
            exp_q.push_back('{s0_req_rw, s0_req_addr, {6'h00, s0_req_addr}, {1'b0, s0_req_tag}});
         if (s1_req_valid && s1_req_ready)
            exp_q.push_back('{s1_req_rw, s1_req_addr, {6'h3f, s1_req_addr}, {1'b1, s1_req_tag}});
      end
   end

   initial begin
      // Reset state
      cyc();
      check("rst_m_req_valid", m_req_valid, 0);
      check("rst_m_req_tag", m_req_tag, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_unexp_rsp, 0);
      reset = 1'b1;
      cyc();

      // Single read with latency and response steering
      drive0(1, 0, 26'h100, 8'h05);
      #1;
      check("single_s0_ready", s0_req_ready, 1);
      check("single_pre_valid", m_req_valid, 0);
      cyc();
      drive0(0, 0, '0, '0);
      check("single_m_valid", m_req_valid, 1);
      check("single_m_tag", m_req_tag, 9'h005);
      check("single_m_addr", m_req_addr, 26'h100);
      check("single_busy", busy, 1);
      check("single_cnt0", dut.cnt_0, 1);
      m_req_ready = 1'b1;
      cyc();
      check("single_drained", m_req_valid, 0);
      check("single_busy_cnt", busy, 1);
      rsp(1, 9'h005);
      s0_rsp_ready = 1'b1;
      #1;
      check("single_rsp0_valid", s0_rsp_valid, 1);
      check("single_rsp1_valid", s1_rsp_valid, 0);
      check("single_rsp_tag", s0_rsp_tag, 8'h05);
      check("single_rsp_data", s0_rsp_data[63:0], 64'hA5A5_A5A5_A5A5_A5A5);
      check("single_m_rsp_ready", m_rsp_ready, 1);
      cyc();
      rsp(0, '0);
      s0_rsp_ready = 1'b0;
      check("single_cnt0_back", dut.cnt_0, 0);
      check("single_busy_clear", busy, 0);

      // Contention: s0 wins first after reset, then strict alternation
      do_reset();
      m_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive0(1, 0, 26'h400 + 26'(i), 8'h10 + 8'(i));
         drive1(1, 0, 26'h800 + 26'(i), 8'h20 + 8'(i));
         #1;
         check("rr_s0_ready", s0_req_ready, (i % 2) == 0);
         check("rr_s1_ready", s1_req_ready, (i % 2) == 1);
         cyc();
         check("rr_tag_msb", m_req_tag[TW], (i % 2) == 1);
      end
      drive0(0, 0, '0, '0);
      drive1(0, 0, '0, '0);
      cyc();
      check("rr_cnt0", dut.cnt_0, 2);
      check("rr_cnt1", dut.cnt_1, 2);

      // Backpressure: obuf held stable, then drain and refill in the same cycle
      do_reset();
      drive0(1, 0, 26'h200, 8'h31);
      cyc();
      drive0(1, 0, 26'h204, 8'h32);
      drive1(1, 0, 26'h208, 8'h41);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_s0_ready", s0_req_ready, 0);
         check("bp_s1_ready", s1_req_ready, 0);
         check("bp_m_tag", m_req_tag, 9'h031);
         check("bp_m_addr", m_req_addr, 26'h200);
         cyc();
      end
      m_req_ready = 1'b1;
      #1;
      check("bp_rel_s1_ready", s1_req_ready, 1);
      check("bp_rel_s0_ready", s0_req_ready, 0);
      cyc();
      check("bp_refill_tag", m_req_tag, 9'h141);
      check("bp_refill_valid", m_req_valid, 1);
      drive1(0, 0, '0, '0);
      cyc();
      check("bp_next_tag", m_req_tag, 9'h032);
      drive0(0, 0, '0, '0);
      cyc();

      // Flow control: s1 capped at 16 reads outstanding, s0 unaffected
      do_reset();
      m_req_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive1(1, 0, 26'hA00 + 26'(i), 8'(i));
         cyc();
      end
      drive1(1, 0, 26'hA10, 8'h10);
      #1;
      check("fc_s1_blocked", s1_req_ready, 0);
      check("fc_cnt1_max", dut.cnt_1, 16);
      drive0(1, 0, 26'h077, 8'h77);
      #1;
      check("fc_s0_ok", s0_req_ready, 1);
      cyc();
      drive0(0, 0, '0, '0);
      rsp(1, 9'h103);
      s0_rsp_ready = 1'b1;
      s1_rsp_ready = 1'b0;
      #1;
      check("fc_rsp_route_ready", m_rsp_ready, 0);
      s1_rsp_ready = 1'b1;
      #1;
      check("fc_rsp1_valid", s1_rsp_valid, 1);
      check("fc_rsp0_valid", s0_rsp_valid, 0);
      check("fc_rsp1_tag", s1_rsp_tag, 8'h03);
      check("fc_still_blocked", s1_req_ready, 0);
      cyc();
      rsp(0, '0);
      s0_rsp_ready = 1'b0;
      s1_rsp_ready = 1'b0;
      #1;
      check("fc_s1_restored", s1_req_ready, 1);
      cyc();
      drive1(0, 0, '0, '0);
      check("fc_cnt1_refill", dut.cnt_1, 16);

      // Write plus simultaneous s1 response
      drive0(1, 1, 26'h300, 8'h55);
      rsp(1, 9'h107);
      s1_rsp_ready = 1'b1;
      #1;
      check("wr_s0_ready", s0_req_ready, 1);
      cyc();
      drive0(0, 0, '0, '0);
      rsp(0, '0);
      s1_rsp_ready = 1'b0;
      check("wr_cnt0_same", dut.cnt_0, 1);
      check("wr_cnt1_dec", dut.cnt_1, 15);
      check("wr_m_rw", m_req_rw, 1);
      cyc();

      // Unexpected response sets the sticky error
      do_reset();
      check("ue_err_clear", err_unexp_rsp, 0);
      rsp(1, 9'h1AA);
      s1_rsp_ready = 1'b1;
      cyc();
      rsp(0, '0);
      s1_rsp_ready = 1'b0;
      check("ue_err_set", err_unexp_rsp, 1);
      check("ue_cnt1_zero", dut.cnt_1, 0);
      repeat (3) cyc();
      check("ue_err_sticky", err_unexp_rsp, 1);

      // Asynchronous reset with obuf full and three reads outstanding
      do_reset();
      m_req_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive0(1, 0, 26'h600 + 26'(i), 8'h60 + 8'(i));
         cyc();
      end
      drive0(0, 0, '0, '0);
      m_req_ready = 1'b0;
      check("mr_cnt0", dut.cnt_0, 3);
      check("mr_obuf_valid", m_req_valid, 1);
      #2;
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("mr_valid_async", m_req_valid, 0);
      check("mr_tag_async", m_req_tag, 0);
      check("mr_busy_async", busy, 0);
      check("mr_cnt0_async", dut.cnt_0, 0);
      cyc();
      reset = 1'b1;
      cyc();

      check("sb_empty", 64'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
